// File: rtl/shift_word_serializer_if.sv
// Valid/ready stream bundle for the word serializer: a wide input word
// stream and a narrow slice stream with first/last framing.
interface shift_word_serializer_if #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [SLICE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_first;
    logic             out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_first, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_first, out_last
    );
endinterface

// File: rtl/shift_word_serializer.sv
// Splits each WIDTH-bit word into NSLICE slices, LSB slice first, with
// first/last framing and a running count of fully emitted words.
module shift_word_serializer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_word_serializer_if.slave bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     word_count
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic             last_q;

    assign idx_d = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg_q <= bus.in_data;
                        idx_q   <= '0;
                        first_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.out_ready) begin
                        if (last_q) begin
                            cnt_q <= cnt_q + 1'b1;
                            // Reload on the last beat keeps the link busy.
                            if (bus.in_valid) begin
                                shreg_q <= bus.in_data;
                                idx_q   <= '0;
                                first_q <= 1'b1;
                                last_q  <= 1'b0;
                            end else begin
                                first_q <= 1'b0;
                                last_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end else begin
                            shreg_q <= shreg_q >> SLICE;
                            idx_q   <= idx_d;
                            first_q <= 1'b0;
                            last_q  <= (idx_d == IDX_LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_data  = shreg_q[SLICE-1:0];
    assign bus.out_valid = (state_q == SHIFT);
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign bus.in_ready  = (state_q == IDLE) || (bus.out_ready && last_q);
    assign busy          = (state_q == SHIFT);
    assign word_count    = cnt_q;
endmodule

// File: tb/tb_shift_word_serializer.sv
// Scoreboard bench for shift_word_serializer: accepted words are expanded
// into expected slices and a negedge monitor checks every cycle.
module tb_shift_word_serializer;
    localparam int W  = 32;
    localparam int S  = 8;
    localparam int C  = 16;
    localparam int NS = W / S;

    typedef struct {
        logic [S-1:0] d;
        logic         f;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         busy;
    logic         busy2;
    logic [C-1:0] wc;
    logic [3:0]   wc2;

    exp_t         q[$];
    logic [C-1:0] exp_cnt = '0;
    logic [3:0]   exp2 = '0;
    int           wraps2 = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    bit           done = 0;

    always #5 clk = ~clk;

    shift_word_serializer_if #(.WIDTH(W), .SLICE(S)) bus ();
    shift_word_serializer_if #(.WIDTH(W), .SLICE(S)) bus2 ();

    shift_word_serializer #(.WIDTH(W), .SLICE(S), .CNT_W(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .word_count (wc)
    );

    shift_word_serializer #(.WIDTH(W), .SLICE(S), .CNT_W(4)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus2),
        .busy       (busy2),
        .word_count (wc2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        forever begin
            @(negedge clk);
            if (bus.in_ready && !rst) break;
            t++;
            if (t > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: word %h not accepted", w);
                break;
            end
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 300);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Issue side: expand each accepted word into its slices.
    initial begin
        logic         a;
        logic [W-1:0] d;
        forever begin
            @(negedge clk);
            a = !rst && bus.in_valid && bus.in_ready;
            d = bus.in_data;
            step();
            if (a)
                for (int i = 0; i < NS; i++)
                    q.push_back('{d: S'(d >> (S * i)),
                                  f: (i == 0), l: (i == NS - 1)});
        end
    end

    // Check side.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = '0;
        end else begin
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
            chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
            chk("in_ready", {31'd0, bus.in_ready},
                {31'd0, (q.size() == 0) || (bus.out_ready && q[0].l)});
            chk("word_count", {16'd0, wc}, {16'd0, exp_cnt});
            if (bus.out_valid && q.size() != 0) begin
                chk("out_data", {24'd0, bus.out_data}, {24'd0, q[0].d});
                chk("out_first", {31'd0, bus.out_first}, {31'd0, q[0].f});
                chk("out_last", {31'd0, bus.out_last}, {31'd0, q[0].l});
                if (bus.out_ready) begin
                    if (q[0].l) exp_cnt = exp_cnt + 1'b1;
                    void'(q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp2 = '0;
        end else begin
            chk("wrap_count", {28'd0, wc2}, {28'd0, exp2});
            if (bus2.out_valid && bus2.out_last) begin
                exp2 = exp2 + 1'b1;
                if (exp2 == 4'd0) wraps2++;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.in_data   = 32'h1234_5678;
        bus2.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_out_first", {31'd0, bus.out_first}, 32'd0);
        chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();

        send(32'hAABBCCDD);
        wait_idle();
        chk("t1_count", {16'd0, wc}, 32'd1);
        step();

        send(32'h04030201);
        send(32'h08070605);
        wait_idle();
        chk("t2_count", {16'd0, wc}, 32'd3);
        step();

        send(32'h11223344);
        step();
        bus.out_ready = 1'b0;
        repeat (3) step();
        bus.out_ready = 1'b1;
        wait_idle();
        step();

        send(32'hA5A5A5A5);
        bus.out_ready = 1'b0;
        fork
            send(32'h5A5A5A5A);
            begin
                repeat (3) step();
                bus.out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("t5_count", {16'd0, wc}, 32'd6);
        step();

        send(32'hDEADBEEF);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_count", {16'd0, wc}, 32'd0);
        step();
        send(32'h00000001);
        wait_idle();
        chk("t4_after", {16'd0, wc}, 32'd1);
        step();

        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send($urandom);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    step();
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_idle();
        chk("final_count", {16'd0, wc}, 32'd61);
        chk("wrap_seen", {31'd0, wraps2 > 0}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
